// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling UART receiver with 3-sample majority vote, optional
//            even/odd parity and stop-bit checking. Optional macro RX_SYNC_EN
//            adds a two-flop input synchronizer on RX_IN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Parity_Error,
    output logic                  Framing_Error
);

    localparam int c_BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_BIT_W-1:0]    c_BIT_LAST = c_BIT_W'(DATA_WIDTH - 1);
    localparam logic [c_BIT_W-1:0]    c_BIT_ONE  = c_BIT_W'(1);
    localparam logic [PRESCALE_W-1:0] c_EDGE_ONE = PRESCALE_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic w_rx;

`ifdef RX_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], RX_IN};
        end
    end

    assign w_rx = r_sync[1];
`else
    assign w_rx = RX_IN;
`endif

    state_t                  r_state,     w_state_nxt;
    logic [PRESCALE_W-1:0]   r_edge,      w_edge_nxt;
    logic [c_BIT_W-1:0]      r_bit,       w_bit_nxt;
    logic [1:0]              r_samp,      w_samp_nxt;
    logic [DATA_WIDTH-1:0]   r_shift,     w_shift_nxt;
    logic                    r_par_fail,  w_par_fail_nxt;
    logic [PRESCALE_W-1:0]   r_pre,       w_pre_nxt;
    logic                    r_par_en,    w_par_en_nxt;
    logic                    r_par_typ,   w_par_typ_nxt;
    logic [DATA_WIDTH-1:0]   w_pdata_nxt;
    logic                    w_dv_nxt, w_pe_nxt, w_fe_nxt;

    logic [PRESCALE_W-1:0]   w_half, w_s_lo, w_s_hi, w_last;
    logic                    w_at_lo, w_at_mid, w_at_hi, w_at_last;
    logic                    w_vote;

    // Sample points are centred on the bit using the latched prescale.
    assign w_half    = {1'b0, r_pre[PRESCALE_W-1:1]};
    assign w_s_lo    = w_half - c_EDGE_ONE;
    assign w_s_hi    = w_half + c_EDGE_ONE;
    assign w_last    = r_pre - c_EDGE_ONE;
    assign w_at_lo   = (r_edge == w_s_lo);
    assign w_at_mid  = (r_edge == w_half);
    assign w_at_hi   = (r_edge == w_s_hi);
    assign w_at_last = (r_edge == w_last);

    // Third sample is taken live so the vote is usable on edge Prescale/2+1.
    assign w_vote = (r_samp[0] & r_samp[1]) | (r_samp[0] & w_rx) | (r_samp[1] & w_rx);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state       <= S_IDLE;
            r_edge        <= '0;
            r_bit         <= '0;
            r_samp        <= '0;
            r_shift       <= '0;
            r_par_fail    <= 1'b0;
            r_pre         <= '0;
            r_par_en      <= 1'b0;
            r_par_typ     <= 1'b0;
            P_DATA        <= '0;
            Data_Valid    <= 1'b0;
            Parity_Error  <= 1'b0;
            Framing_Error <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_edge        <= w_edge_nxt;
            r_bit         <= w_bit_nxt;
            r_samp        <= w_samp_nxt;
            r_shift       <= w_shift_nxt;
            r_par_fail    <= w_par_fail_nxt;
            r_pre         <= w_pre_nxt;
            r_par_en      <= w_par_en_nxt;
            r_par_typ     <= w_par_typ_nxt;
            P_DATA        <= w_pdata_nxt;
            Data_Valid    <= w_dv_nxt;
            Parity_Error  <= w_pe_nxt;
            Framing_Error <= w_fe_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_edge_nxt     = r_edge;
        w_bit_nxt      = r_bit;
        w_samp_nxt     = r_samp;
        w_shift_nxt    = r_shift;
        w_par_fail_nxt = r_par_fail;
        w_pre_nxt      = r_pre;
        w_par_en_nxt   = r_par_en;
        w_par_typ_nxt  = r_par_typ;
        w_pdata_nxt    = P_DATA;
        w_dv_nxt       = 1'b0;
        w_pe_nxt       = 1'b0;
        w_fe_nxt       = 1'b0;

        if (r_state != S_IDLE) begin
            w_edge_nxt = w_at_last ? '0 : r_edge + c_EDGE_ONE;
            if (w_at_lo) begin
                w_samp_nxt[0] = w_rx;
            end
            if (w_at_mid) begin
                w_samp_nxt[1] = w_rx;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (!w_rx) begin
                    w_state_nxt    = S_START;
                    w_edge_nxt     = c_EDGE_ONE;
                    w_bit_nxt      = '0;
                    w_par_fail_nxt = 1'b0;
                    w_pre_nxt      = Prescale;
                    w_par_en_nxt   = PAR_EN;
                    w_par_typ_nxt  = PAR_TYP;
                end
            end
            S_START: begin
                if (w_at_hi && w_vote) begin
                    w_state_nxt = S_IDLE;
                    w_edge_nxt  = '0;
                end else if (w_at_last) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_at_hi) begin
                    w_shift_nxt = {w_vote, r_shift[DATA_WIDTH-1:1]};
                end
                if (w_at_last) begin
                    if (r_bit == c_BIT_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + c_BIT_ONE;
                    end
                end
            end
            S_PARITY: begin
                if (w_at_hi && (w_vote != ((^r_shift) ^ r_par_typ))) begin
                    w_par_fail_nxt = 1'b1;
                end
                if (w_at_last) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // Leave mid stop bit so a drifting sender's next start is caught.
                if (w_at_hi) begin
                    w_state_nxt = S_IDLE;
                    w_edge_nxt  = '0;
                    if (!w_vote) begin
                        w_fe_nxt = 1'b1;
                    end else if (r_par_fail) begin
                        w_pe_nxt = 1'b1;
                    end else begin
                        w_dv_nxt    = 1'b1;
                        w_pdata_nxt = r_shift;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_edge_nxt  = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx: vector table, corner sequences
//            and random frames scored against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

`ifdef RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [7:0] P_DATA;
    logic       Data_Valid, Parity_Error, Framing_Error;

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .P_DATA       (P_DATA),
        .Data_Valid   (Data_Valid),
        .Parity_Error (Parity_Error),
        .Framing_Error(Framing_Error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         t;
        logic [2:0] kind;   // {dv, pe, fe}
        logic [7:0] d;
    } ev_t;

    typedef struct {
        int         pre;
        bit         pen;
        bit         ptyp;
        logic [7:0] data;
        bit         pb;
        bit         stop;
        logic [2:0] kind;
        logic [7:0] pdata;
        int         lat;
    } vec_t;

    ev_t        obs_q[$];
    ev_t        exp_q[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         hold_viol = 0;
    logic [7:0] prev_pdata = 8'h00;
    logic [7:0] m_pdata = 8'h00;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RST && (Data_Valid || Parity_Error || Framing_Error)) begin
            obs_q.push_back('{t: cyc, kind: {Data_Valid, Parity_Error, Framing_Error}, d: P_DATA});
        end
        if (RST && !Data_Valid && (P_DATA !== prev_pdata)) hold_viol++;
        prev_pdata = P_DATA;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic b, input int n);
        RX_IN = b;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Whole frame; config inputs are scrambled once the start bit is seen.
    task automatic send_frame(input int pre, input bit pen, input bit ptyp, input logic [7:0] d,
                              input bit pb, input bit stop, output int t0);
        Prescale = 6'(pre);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        t0       = cyc;
        drive(1'b0, 1);
        Prescale = 6'(2 * $urandom_range(2, 16));
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
        drive(1'b0, pre - 1);
        for (int i = 0; i < 8; i++) drive(d[i], pre);
        if (pen) drive(pb, pre);
        if (stop) begin
            drive(1'b1, pre);
        end else begin
            drive(1'b0, pre / 2 + 2);
            drive(1'b1, pre - pre / 2 - 2);
        end
    endtask

    // Frame-level reference: outcome from line contents, timing from bit count.
    task automatic model_push(input int t0, input int pre, input bit pen, input bit ptyp,
                              input logic [7:0] d, input bit pb, input bit stop);
        ev_t e;
        e.t = t0 + (9 + int'(pen)) * pre + pre / 2 + 2 + SYNC_LAT;
        if (!stop) begin
            e.kind = 3'b001;
        end else if (pen && (pb != ((^d) ^ ptyp))) begin
            e.kind = 3'b010;
        end else begin
            e.kind  = 3'b100;
            m_pdata = d;
        end
        e.d = m_pdata;
        exp_q.push_back(e);
    endtask

    task automatic check_events(input string tag);
        int n;
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
            chk({tag, "_time"}, obs_q[i].t, exp_q[i].t);
            chk({tag, "_pdata"}, obs_q[i].d, exp_q[i].d);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    vec_t vecs[6];

    initial begin
        int t0;
        int t1;
        int p;
        bit pen, ptyp, pb, stop;
        logic [7:0] d;
        ev_t e;

        vecs[0] = '{8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 3'b100, 8'hA5, 78};
        vecs[1] = '{16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 3'b100, 8'h3C, 170};
        vecs[2] = '{16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 3'b010, 8'h3C, 170};
        vecs[3] = '{8,  1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 3'b001, 8'h3C, 86};
        vecs[4] = '{4,  1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 3'b100, 8'h00, 44};
        vecs[5] = '{32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 3'b100, 8'hFF, 306};

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("reset_pdata", P_DATA, 8'h00);
        chk("reset_dv", Data_Valid, 1'b0);
        chk("reset_pe", Parity_Error, 1'b0);
        chk("reset_fe", Framing_Error, 1'b0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        drive(1'b1, 4);

        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].pre, vecs[i].pen, vecs[i].ptyp, vecs[i].data,
                       vecs[i].pb, vecs[i].stop, t0);
            drive(1'b1, 8);
            e.t    = t0 + vecs[i].lat + SYNC_LAT;
            e.kind = vecs[i].kind;
            e.d    = vecs[i].pdata;
            exp_q.push_back(e);
            check_events($sformatf("vec%0d", i));
        end
        m_pdata = 8'hFF;

        // Start-bit glitch then a clean frame
        Prescale = 6'd8;
        drive(1'b0, 3);
        drive(1'b1, 12);
        send_frame(8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, t0);
        model_push(t0, 8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1);
        drive(1'b1, 8);
        check_events("glitch");

        // Back-to-back frames, no idle gap
        send_frame(32, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, t0);
        send_frame(32, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1, t1);
        model_push(t0, 32, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1);
        model_push(t1, 32, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b1);
        drive(1'b1, 8);
        check_events("b2b");

        // Reset in the middle of data bit 4
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        drive(1'b0, 8);
        for (int i = 0; i < 4; i++) drive(1'b1, 8);
        drive(1'b0, 3);
        RST = 1'b0;
        drive(1'b1, 4);
        @(negedge CLK);
        chk("midrst_pdata", P_DATA, 8'h00);
        chk("midrst_dv", Data_Valid, 1'b0);
        chk("midrst_pe", Parity_Error, 1'b0);
        chk("midrst_fe", Framing_Error, 1'b0);
        @(posedge CLK);
        #1;
        RST     = 1'b1;
        m_pdata = 8'h00;
        drive(1'b1, 12);
        send_frame(8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, t0);
        model_push(t0, 8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1);
        drive(1'b1, 8);
        check_events("midrst");

        // Random frames with random gaps (including none)
        for (int i = 0; i < 40; i++) begin
            p    = 2 * $urandom_range(2, 16);
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            d    = 8'($urandom);
            pb   = (^d) ^ ptyp;
            if ($urandom_range(0, 3) == 0) pb = ~pb;
            stop = ($urandom_range(0, 4) != 0);
            send_frame(p, pen, ptyp, d, pb, stop, t0);
            model_push(t0, p, pen, ptyp, d, pb, stop);
            drive(1'b1, $urandom_range(0, 3));
        end
        drive(1'b1, 40);
        check_events("rand");

        chk("pdata_hold_violations", hold_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver. The counterpart of the team's UART TX path: it recovers frames that the TX serializer and framer put on the line.
- Oversamples RX_IN at Prescale CLK cycles per bit and majority-votes three mid-bit samples.
- Deserializes the data LSB-first, with optional even/odd parity checking and stop-bit checking.
- Presents the parallel byte with a single-cycle valid strobe to the system-side consumer (register file / FIFO).

Parameters:
DATA_WIDTH, 8, number of data bits per frame.
PRESCALE_W, 6, width of the Prescale input. Supported Prescale values are even numbers from 4 to 32.

Ports:
CLK  input  1  oversampling clock; CLK frequency = Prescale × baud.
RST  input  1  asynchronous active-low reset.
RX_IN  input  1  serial line, idle high.
Prescale  input  PRESCALE_W  CLK cycles per bit; even, 4..32.
PAR_EN  input  1  1 = frame contains a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
P_DATA  output  DATA_WIDTH  last good received data word.
Data_Valid  output  1  one-cycle pulse when P_DATA is updated.
Parity_Error  output  1  one-cycle pulse at frame end on parity mismatch.
Framing_Error  output  1  one-cycle pulse at frame end when the stop bit is sampled 0.

Behaviour:
- Reset:
  - FSM goes to IDLE; edge and bit counters clear to 0.
  - P_DATA = 0; Data_Valid, Parity_Error and Framing_Error = 0.
  - Reset asserted mid-frame aborts the frame immediately; no strobe is issued.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Edge counter runs 0..Prescale-1 within each bit. Bit counter counts data bits 0..DATA_WIDTH-1.
- IDLE:
  - The first cycle with RX_IN = 0 is edge 0 of the start bit. Next state is START with edge_cnt = 1.
- Sampling, in every state except IDLE:
  - RX_IN is captured at edges Prescale/2-1, Prescale/2 and Prescale/2+1.
  - Bit value = majority of the 3 samples, valid from edge Prescale/2+1.
- START:
  - At edge Prescale/2+1, a voted 1 is a glitch: return to IDLE next cycle, no strobe.
  - Otherwise move to DATA after edge Prescale-1.
- DATA:
  - The voted bit is shifted in LSB-first into an internal shift register.
  - After DATA_WIDTH bits, go to PARITY if PAR_EN = 1, else to STOP.
- PARITY:
  - Expected bit = XOR of the data bits, inverted when PAR_TYP = 1.
  - A mismatch sets an internal parity-fail flag.
  - Go to STOP after edge Prescale-1.
- STOP: the bit is evaluated at edge Prescale/2+1. On the next cycle:
  - Framing_Error pulses if the voted stop bit is 0.
  - Otherwise Parity_Error pulses if the parity-fail flag is set.
  - Otherwise Data_Valid pulses and P_DATA loads the shift register in the same cycle.
  - In all cases the FSM returns to IDLE in that same cycle, half a bit early to tolerate baud drift. A low RX_IN from then on starts a new frame (back-to-back frames supported).
- Error priority: Framing_Error over Parity_Error. Exactly one of the three strobes fires per completed frame. Strobes never overlap and are never held longer than one cycle.
- P_DATA changes only on Data_Valid and holds its value otherwise, including across errored frames.
- Configuration latching: Prescale, PAR_EN and PAR_TYP are latched on the IDLE→START transition. Changes mid-frame do not affect the current frame.
- Width rule: edge_cnt is PRESCALE_W bits wide and wraps to 0 at Prescale-1, never at its natural limit.

Optional Feature:
RX_SYNC_EN:
- When defined, RX_IN passes through a two-flop synchronizer, reset value 1, before all logic. All timing is shifted by 2 CLK cycles.
- When undefined, RX_IN is used directly; the source must already be synchronous to CLK.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA5 starting at cycle 0 → Data_Valid pulses only at cycle 78, P_DATA=0xA5, no errors (add 2 cycles with RX_SYNC_EN).
- Prescale=16, PAR_EN=1, PAR_TYP=0, data 0x3C with parity 0 → Data_Valid, P_DATA=0x3C. Repeat with parity bit 1 → Parity_Error pulse at cycle 10×16+9+1=170, P_DATA unchanged.
- Prescale=8, stop bit driven 0 with a bad parity bit → only Framing_Error pulses; P_DATA retains the previous value.
- Prescale=8, RX_IN low for 3 cycles then high → returns to IDLE, no strobe. A following valid 0x5A frame is received correctly.
- Two back-to-back frames 0x01 then 0xFE with the second start bit immediately after the stop bit, Prescale=32 → two Data_Valid pulses with the correct data in order.
- RST asserted at data bit 4, then a clean 0x81 frame → all outputs 0 during reset, then 0x81 is received.
